// File: rtl/mux_rr_stream.sv
// -----------------------------------------------------------------------------
// mux_rr_stream
//   4-to-1 stream multiplexer with round-robin arbitration. Merges four
//   valid/ready source channels onto one registered output stream and tags
//   every beat with its source index so a downstream demux can route it back.
//
// Configuration macro:
//   MUX_PKT_LOCK_EN  when defined, once a beat with in_last=0 is accepted
//                    from a channel, arbitration stays on that channel until
//                    its in_last=1 beat is accepted. When undefined,
//                    arbitration is per-beat and in_last is only forwarded.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous reset, active-low
//   in0..in3   in   WIDTH  channel data
//   in_valid   in   4      bit i: channel i offers a beat
//   in_last    in   4      bit i: beat on channel i ends a packet
//   in_ready   out  4      bit i: channel i beat accepted this cycle (comb)
//   out        out  WIDTH  registered output data
//   out_sel    out  2      source channel index of the current out beat
//   out_last   out  1      registered copy of the winner's in_last
//   out_valid  out  1      output register holds a beat
//   out_ready  in   1      sink accepts beat
// -----------------------------------------------------------------------------
module mux_rr_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [3:0]       in_valid,
  input  logic [3:0]       in_last,
  output logic [3:0]       in_ready,
  output logic [WIDTH-1:0] out,
  output logic [1:0]       out_sel,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] inData [4];
  logic [WIDTH-1:0] outData_q;
  logic [1:0]       outSel_q;
  logic             outLast_q;
  logic             outValid_q;
  logic [1:0]       rrPtr_q;
  logic [1:0]       rrPtr_d;
  logic             loadOk;
  logic [3:0]       eligible;
  logic             found;
  logic [1:0]       winner;
  logic             accept;

  assign inData[0] = in0;
  assign inData[1] = in1;
  assign inData[2] = in2;
  assign inData[3] = in3;

  // The output register can take a new beat when empty or when it drains now.
  assign loadOk = !outValid_q || out_ready;

`ifdef MUX_PKT_LOCK_EN
  typedef enum logic {UNLOCKED, LOCKED} lockState_e;

  lockState_e lockState_q;
  logic [1:0] lockCh_q;

  // While a packet is in flight only its channel may compete.
  always_comb begin
    eligible = in_valid;
    if (lockState_q == LOCKED) begin
      eligible = in_valid & (4'b0001 << lockCh_q);
    end
  end
`else
  assign eligible = in_valid;
`endif

  // Rotating priority search starting at rrPtr_q, wrapping 3 -> 0.
  always_comb begin
    logic [1:0] idx;
    found  = 1'b0;
    winner = rrPtr_q;
    idx    = '0;
    for (int k = 0; k < 4; k++) begin
      idx = rrPtr_q + 2'(k);
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // rst_n gates the grant so no handshake is signalled while in reset.
  assign accept   = rst_n && loadOk && found;
  assign in_ready = accept ? (4'b0001 << winner) : 4'b0000;
  assign rrPtr_d  = accept ? (winner + 2'd1) : rrPtr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outData_q  <= '0;
      outSel_q   <= '0;
      outLast_q  <= 1'b0;
      outValid_q <= 1'b0;
      rrPtr_q    <= '0;
    end else begin
      rrPtr_q <= rrPtr_d;
      if (accept) begin
        outData_q  <= inData[winner];
        outSel_q   <= winner;
        outLast_q  <= in_last[winner];
        outValid_q <= 1'b1;
      end else if (loadOk) begin
        // Held beat drained with nothing to replace it; data is left as is.
        outValid_q <= 1'b0;
      end
    end
  end

`ifdef MUX_PKT_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lockState_q <= UNLOCKED;
      lockCh_q    <= '0;
    end else if (accept) begin
      if (!in_last[winner]) begin
        lockState_q <= LOCKED;
        lockCh_q    <= winner;
      end else begin
        lockState_q <= UNLOCKED;
      end
    end
  end
`endif

  assign out       = outData_q;
  assign out_sel   = outSel_q;
  assign out_last  = outLast_q;
  assign out_valid = outValid_q;

endmodule

// File: tb/tb_mux_rr_stream.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_stream
//   Self-checking bench for mux_rr_stream. A reference model predicts grants
//   and pushes expected beats into a scoreboard queue; beats are popped and
//   compared as the DUT presents them on the output.
// -----------------------------------------------------------------------------
module tb_mux_rr_stream;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] inD [4];
  logic [3:0]       in_valid;
  logic [3:0]       in_last;
  logic [3:0]       in_ready;
  logic [WIDTH-1:0] out;
  logic [1:0]       out_sel;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model state.
  logic [1:0]       mPtr;
  logic             mOutValid;
  logic             mLocked;
  logic [1:0]       mLockCh;
  logic [WIDTH+2:0] sbQ [$];
  int               obsSel [$];

  mux_rr_stream #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0       (inD[0]),
    .in1       (inD[1]),
    .in2       (inD[2]),
    .in3       (inD[3]),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out       (out),
    .out_sel   (out_sel),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelReset();
    mPtr      = 2'd0;
    mOutValid = 1'b0;
    mLocked   = 1'b0;
    mLockCh   = 2'd0;
    sbQ.delete();
  endtask

  // Evaluates one cycle: checks outputs against the model, then advances to
  // the next falling edge. Inputs must already be set. acc = granted channel.
  task automatic step(output int acc);
    logic [3:0]       expReady;
    logic [3:0]       mask;
    logic             loadOk;
    logic [WIDTH+2:0] exp;
    int               w;
    int               idx;
    #1;
    assertCount++;
    if (out_valid !== mOutValid) begin
      failCount++;
      $display("[TB] FAIL out_valid: got %b expected %b at %0t", out_valid, mOutValid, $time);
    end
    if (mOutValid && sbQ.size() > 0) begin
      exp = sbQ[0];
      assertCount++;
      if ({out, out_sel, out_last} !== exp) begin
        failCount++;
        $display("[TB] FAIL out_beat: got data=%h sel=%0d last=%b expected data=%h sel=%0d last=%b at %0t",
                 out, out_sel, out_last, exp[WIDTH+2:3], exp[2:1], exp[0], $time);
      end
      if (out_ready) begin
        obsSel.push_back(int'(out_sel));
        void'(sbQ.pop_front());
      end
    end
    loadOk = !mOutValid || out_ready;
    mask   = in_valid;
`ifdef MUX_PKT_LOCK_EN
    if (mLocked) mask = in_valid & (4'b0001 << mLockCh);
`endif
    w = -1;
    for (int k = 0; k < 4; k++) begin
      idx = (int'(mPtr) + k) % 4;
      if (w < 0 && mask[idx]) w = idx;
    end
    acc      = -1;
    expReady = 4'b0000;
    if (loadOk && w >= 0) begin
      expReady[w] = 1'b1;
      acc         = w;
      sbQ.push_back({inD[w], 2'(w), in_last[w]});
      mOutValid   = 1'b1;
      mPtr        = 2'((w + 1) % 4);
      if (!in_last[w]) begin
        mLocked = 1'b1;
        mLockCh = 2'(w);
      end else begin
        mLocked = 1'b0;
      end
    end else if (loadOk) begin
      mOutValid = 1'b0;
    end
    assertCount++;
    if (in_ready !== expReady) begin
      failCount++;
      $display("[TB] FAIL in_ready: got %b expected %b at %0t", in_ready, expReady, $time);
    end
    @(negedge clk);
  endtask

  task automatic pulseReset();
    in_valid = 4'b0000;
    in_last  = 4'b0000;
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  task automatic test_reset();
    int acc;
    rst_n     = 1'b0;
    in_valid  = 4'hF;
    in_last   = 4'hF;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) inD[i] = 8'(8'h50 + i);
    #3;
    assertCount++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0000 || out !== 8'h00 ||
        out_sel !== 2'd0 || out_last !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_state: got valid=%b ready=%b out=%h sel=%0d last=%b expected 0 0000 00 0 0",
               out_valid, in_ready, out, out_sel, out_last);
    end
    @(negedge clk);
    assertCount++;
    if (in_ready !== 4'b0000) begin
      failCount++;
      $display("[TB] FAIL reset_ready: got %b expected 0000", in_ready);
    end
    in_valid = 4'b0000;
    rst_n    = 1'b1;
    modelReset();
    step(acc);
  endtask

  task automatic test_single();
    int acc;
    inD[2]   = 8'hA5;
    in_last  = 4'b0100;
    in_valid = 4'b0100;
    step(acc);
    in_valid = 4'b0000;
    #1;
    assertCount++;
    if (out !== 8'hA5 || out_sel !== 2'd2 || out_valid !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL single_beat: got out=%h sel=%0d valid=%b expected A5 2 1", out, out_sel, out_valid);
    end
    step(acc);
    step(acc);
  endtask

  task automatic test_fairness();
    int acc;
    pulseReset();
    obsSel.delete();
    in_valid  = 4'hF;
    in_last   = 4'hF;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 4; i++) inD[i] = 8'($urandom_range(0, 255));
      step(acc);
      assertCount++;
      if (acc < 0) begin
        failCount++;
        $display("[TB] FAIL fair_throughput: cycle %0d got no grant expected one", c);
      end
    end
    in_valid = 4'b0000;
    step(acc);
    step(acc);
    assertCount++;
    if (obsSel.size() != 8) begin
      failCount++;
      $display("[TB] FAIL fair_count: got %0d beats expected 8", obsSel.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        assertCount++;
        if (obsSel[i] != i % 4) begin
          failCount++;
          $display("[TB] FAIL fair_seq[%0d]: got %0d expected %0d", i, obsSel[i], i % 4);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    inD[0]    = 8'h3C;
    in_last   = 4'b1111;
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    step(acc);
    out_ready = 1'b0;
    in_valid  = 4'b1010;
    inD[1]    = 8'h11;
    inD[3]    = 8'h33;
    for (int c = 0; c < 5; c++) begin
      step(acc);
      #1;
      assertCount++;
      if (out !== 8'h3C || out_sel !== 2'd0 || in_ready !== 4'b0000) begin
        failCount++;
        $display("[TB] FAIL bp_hold: got out=%h sel=%0d ready=%b expected 3C 0 0000", out, out_sel, in_ready);
      end
      #(-0);
    end
    out_ready = 1'b1;
    step(acc);
    in_valid = 4'b0000;
    step(acc);
    step(acc);
    step(acc);
  endtask

  task automatic test_lock();
    int acc;
    int ch1Cnt;
    bit ch0Done;
    bit ch3Done;
    int expSeq [6];
    bit done;
    pulseReset();
    obsSel.delete();
    out_ready = 1'b1;
    inD[0]    = 8'h0F;
    in_last   = 4'b0001;
    in_valid  = 4'b0001;
    step(acc);
    ch1Cnt  = 0;
    ch0Done = 1'b0;
    ch3Done = 1'b0;
    done    = 1'b0;
    for (int c = 0; c < 12 && !done; c++) begin
      in_valid  = {!ch3Done, 1'b0, ch1Cnt < 3, !ch0Done};
      in_last   = {1'b1, 1'b0, ch1Cnt == 2, 1'b1};
      inD[0]    = 8'hC0;
      inD[1]    = 8'(8'h10 + ch1Cnt);
      inD[3]    = 8'hC3;
      step(acc);
      if (acc == 1) ch1Cnt++;
      if (acc == 0) ch0Done = 1'b1;
      if (acc == 3) ch3Done = 1'b1;
      done = (ch1Cnt == 3) && ch0Done && ch3Done;
    end
    assertCount++;
    if (!done) begin
      failCount++;
      $display("[TB] FAIL lock_timeout: got ch1=%0d ch0=%b ch3=%b expected all sent", ch1Cnt, ch0Done, ch3Done);
    end
    in_valid = 4'b0000;
    step(acc);
    step(acc);
`ifdef MUX_PKT_LOCK_EN
    expSeq = '{0, 1, 1, 1, 3, 0};
`else
    expSeq = '{0, 1, 3, 0, 1, 1};
`endif
    assertCount++;
    if (obsSel.size() != 6) begin
      failCount++;
      $display("[TB] FAIL lock_count: got %0d beats expected 6", obsSel.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        assertCount++;
        if (obsSel[i] != expSeq[i]) begin
          failCount++;
          $display("[TB] FAIL lock_seq[%0d]: got %0d expected %0d", i, obsSel[i], expSeq[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    int acc;
    out_ready = 1'b1;
    inD[2]    = 8'h77;
    in_last   = 4'b1111;
    in_valid  = 4'b0100;
    step(acc);
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    #2 rst_n  = 1'b0;
    #1;
    assertCount++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
      failCount++;
      $display("[TB] FAIL midreset_async: got valid=%b ready=%b expected 0 0000", out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    in_valid  = 4'hF;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) inD[i] = 8'(8'hE0 + i);
    #1;
    assertCount++;
    if (in_ready !== 4'b0001) begin
      failCount++;
      $display("[TB] FAIL midreset_grant: got %b expected 0001", in_ready);
    end
    step(acc);
    in_valid = 4'b0000;
    step(acc);
    step(acc);
  endtask

  initial begin
    in_valid  = 4'b0000;
    in_last   = 4'b0000;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    for (int i = 0; i < 4; i++) inD[i] = '0;
    modelReset();
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_lock();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
